// File: rtl/pokemon_select_ctrl.sv
// Two-player character-select controller: grid cursors, lock FSMs, stat table.
// Latency: cursor/lock visible 1 edge after a key press, stats 1 edge after the id.
// Backpressure: none; level keys are edge-detected, fight/win/other scenes freeze state.
module pokemon_select_ctrl #(
  parameter int COLS   = 4,
  parameter int ROWS   = 2,
  parameter int WRAP   = 0,
  parameter int UNIQUE = 1,
  parameter int W      = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   scene_state,
  input  logic [4:0]   p1_keys,
  input  logic [4:0]   p2_keys,
  input  logic         cfg_we,
  input  logic [3:0]   cfg_idx,
  input  logic [2:0]   cfg_field,
  input  logic [W-1:0] cfg_data,
  output logic [W-1:0] p1_id,
  output logic [W-1:0] p2_id,
  output logic [W-1:0] p1_hp,
  output logic [W-1:0] p1_speed,
  output logic [W-1:0] p1_sk1,
  output logic [W-1:0] p1_sk2,
  output logic [W-1:0] p1_sk3,
  output logic [W-1:0] p2_hp,
  output logic [W-1:0] p2_speed,
  output logic [W-1:0] p2_sk1,
  output logic [W-1:0] p2_sk2,
  output logic [W-1:0] p2_sk3,
  output logic         p1_locked,
  output logic         p2_locked,
  output logic         sel_done
);
  localparam int N = COLS * ROWS;

  typedef enum logic [1:0] {S_IDLE, S_BROWSE, S_LOCKED} state_t;

  // Key bits {U,D,L,R,C}; returns the id after one direction step.
  function automatic logic [W-1:0] f_move(input logic [W-1:0] id, input logic [3:0] dir);
    int p, row, col;
    p   = int'(id) - 1;
    row = p / COLS;
    col = p % COLS;
    if (dir[3]) begin
      if (row > 0) row = row - 1;
      else if (WRAP != 0) row = ROWS - 1;
    end else if (dir[2]) begin
      if (row < ROWS - 1) row = row + 1;
      else if (WRAP != 0) row = 0;
    end else if (dir[1]) begin
      if (col > 0) col = col - 1;
      else if (WRAP != 0) col = COLS - 1;
    end else if (dir[0]) begin
      if (col < COLS - 1) col = col + 1;
      else if (WRAP != 0) col = 0;
    end
    return W'(row * COLS + col + 1);
  endfunction

  logic [W-1:0] r_tbl_hp [16];
  logic [W-1:0] r_tbl_sp [16];
  logic [W-1:0] r_tbl_s1 [16];
  logic [W-1:0] r_tbl_s2 [16];
  logic [W-1:0] r_tbl_s3 [16];

  logic [4:0]   r_p1_prev, r_p2_prev;
  state_t       r_p1_st, r_p2_st, w_p1_st_nx, w_p2_st_nx;
  logic [W-1:0] r_p1_id, r_p2_id, w_p1_id_nx, w_p2_id_nx;
  logic         r_sel_done;
  logic [W-1:0] r_p1_hp, r_p1_sp, r_p1_s1, r_p1_s2, r_p1_s3;
  logic [W-1:0] r_p2_hp, r_p2_sp, r_p2_s1, r_p2_s2, r_p2_s3;

  logic [4:0] w_p1_pr, w_p2_pr;
  logic       w_p1_one, w_p2_one;
  logic       w_start, w_choose, w_run;
  logic       w_p1_ok, w_p2_ok, w_p1_locking;
  logic [3:0] w_p1_idx, w_p2_idx;

  assign w_start  = (scene_state == 4'd1);
  assign w_choose = (scene_state == 4'd2);
  assign w_run    = w_start | w_choose;

  // Rising-edge presses; a cycle is usable only when exactly one new press arrives.
  assign w_p1_pr  = p1_keys & ~r_p1_prev;
  assign w_p2_pr  = p2_keys & ~r_p2_prev;
  assign w_p1_one = (w_p1_pr != 5'd0) && ((w_p1_pr & (w_p1_pr - 5'd1)) == 5'd0);
  assign w_p2_one = (w_p2_pr != 5'd0) && ((w_p2_pr & (w_p2_pr - 5'd1)) == 5'd0);

  assign w_p1_idx = 4'(r_p1_id - W'(1));
  assign w_p2_idx = 4'(r_p2_id - W'(1));

  // Stat table: reset to the built-in roster, overwritten by in-range config writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        r_tbl_hp[i] <= W'(50 + 20 * i);
        r_tbl_sp[i] <= W'(250 - 15 * i);
        r_tbl_s1[i] <= W'(30);
        r_tbl_s2[i] <= W'(40);
        r_tbl_s3[i] <= W'(50);
      end
    end else if (cfg_we && ({1'b0, cfg_idx} < 5'(N))) begin
      case (cfg_field)
        3'd0:    r_tbl_hp[cfg_idx] <= cfg_data;
        3'd1:    r_tbl_sp[cfg_idx] <= cfg_data;
        3'd2:    r_tbl_s1[cfg_idx] <= cfg_data;
        3'd3:    r_tbl_s2[cfg_idx] <= cfg_data;
        3'd4:    r_tbl_s3[cfg_idx] <= cfg_data;
        default: ;
      endcase
    end
  end

  // Next state and cursor for both players; p1 is resolved first so it wins a tie.
  always_comb begin
    w_p1_st_nx   = r_p1_st;
    w_p2_st_nx   = r_p2_st;
    w_p1_id_nx   = r_p1_id;
    w_p2_id_nx   = r_p2_id;
    w_p1_ok      = !((UNIQUE != 0) && (r_p2_st == S_LOCKED) && (r_p2_id == r_p1_id));
    w_p1_locking = 1'b0;
    w_p2_ok      = 1'b1;
    if (w_start) begin
      w_p1_st_nx = S_IDLE;
      w_p2_st_nx = S_IDLE;
      w_p1_id_nx = W'(1);
      w_p2_id_nx = W'(N);
    end else if (w_choose) begin
      case (r_p1_st)
        S_IDLE:   w_p1_st_nx = S_BROWSE;
        S_BROWSE: if (w_p1_one) begin
          if (w_p1_pr[0]) begin
            if (w_p1_ok) w_p1_st_nx = S_LOCKED;
          end else begin
            w_p1_id_nx = f_move(r_p1_id, w_p1_pr[4:1]);
          end
        end
        S_LOCKED: if (w_p1_one && w_p1_pr[0]) w_p1_st_nx = S_BROWSE;
        default:  w_p1_st_nx = S_IDLE;
      endcase
      w_p1_locking = (r_p1_st == S_BROWSE) && (w_p1_st_nx == S_LOCKED);
      w_p2_ok = !((UNIQUE != 0) && (r_p1_id == r_p2_id) &&
                  ((r_p1_st == S_LOCKED) || w_p1_locking));
      case (r_p2_st)
        S_IDLE:   w_p2_st_nx = S_BROWSE;
        S_BROWSE: if (w_p2_one) begin
          if (w_p2_pr[0]) begin
            if (w_p2_ok) w_p2_st_nx = S_LOCKED;
          end else begin
            w_p2_id_nx = f_move(r_p2_id, w_p2_pr[4:1]);
          end
        end
        S_LOCKED: if (w_p2_one && w_p2_pr[0]) w_p2_st_nx = S_BROWSE;
        default:  w_p2_st_nx = S_IDLE;
      endcase
    end
  end

  // Player state, cursors, key history and the done flag (held outside start/choose).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p1_st    <= S_IDLE;
      r_p2_st    <= S_IDLE;
      r_p1_id    <= W'(1);
      r_p2_id    <= W'(N);
      r_p1_prev  <= 5'd0;
      r_p2_prev  <= 5'd0;
      r_sel_done <= 1'b0;
    end else begin
      r_p1_st   <= w_p1_st_nx;
      r_p2_st   <= w_p2_st_nx;
      r_p1_id   <= w_p1_id_nx;
      r_p2_id   <= w_p2_id_nx;
      r_p1_prev <= p1_keys;
      r_p2_prev <= p2_keys;
      if (w_run)
        r_sel_done <= w_choose && (r_p1_st == S_LOCKED) && (r_p2_st == S_LOCKED);
    end
  end

  // Registered stat lookups at the current ids, frozen outside start/choose.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p1_hp <= W'(50);
      r_p1_sp <= W'(250);
      r_p1_s1 <= W'(30);
      r_p1_s2 <= W'(40);
      r_p1_s3 <= W'(50);
      r_p2_hp <= W'(50 + 20 * (N - 1));
      r_p2_sp <= W'(250 - 15 * (N - 1));
      r_p2_s1 <= W'(30);
      r_p2_s2 <= W'(40);
      r_p2_s3 <= W'(50);
    end else if (w_run) begin
      r_p1_hp <= r_tbl_hp[w_p1_idx];
      r_p1_sp <= r_tbl_sp[w_p1_idx];
      r_p1_s1 <= r_tbl_s1[w_p1_idx];
      r_p1_s2 <= r_tbl_s2[w_p1_idx];
      r_p1_s3 <= r_tbl_s3[w_p1_idx];
      r_p2_hp <= r_tbl_hp[w_p2_idx];
      r_p2_sp <= r_tbl_sp[w_p2_idx];
      r_p2_s1 <= r_tbl_s1[w_p2_idx];
      r_p2_s2 <= r_tbl_s2[w_p2_idx];
      r_p2_s3 <= r_tbl_s3[w_p2_idx];
    end
  end

  assign p1_id     = r_p1_id;
  assign p2_id     = r_p2_id;
  assign p1_locked = (r_p1_st == S_LOCKED);
  assign p2_locked = (r_p2_st == S_LOCKED);
  assign sel_done  = r_sel_done;
  assign p1_hp     = r_p1_hp;
  assign p1_speed  = r_p1_sp;
  assign p1_sk1    = r_p1_s1;
  assign p1_sk2    = r_p1_s2;
  assign p1_sk3    = r_p1_s3;
  assign p2_hp     = r_p2_hp;
  assign p2_speed  = r_p2_sp;
  assign p2_sk1    = r_p2_s1;
  assign p2_sk2    = r_p2_s2;
  assign p2_sk3    = r_p2_s3;
endmodule

// File: tb/tb_pokemon_select_ctrl.sv
// Directed bench: clamping instance (dut) plus a wrap-around instance (dut_w) on shared inputs.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Each check is an immediate assertion that counts and reports failures.
module tb_pokemon_select_ctrl;
  localparam logic [4:0] K_U = 5'b10000;
  localparam logic [4:0] K_D = 5'b01000;
  localparam logic [4:0] K_L = 5'b00100;
  localparam logic [4:0] K_R = 5'b00010;
  localparam logic [4:0] K_C = 5'b00001;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] scene_state;
  logic [4:0] p1_keys, p2_keys;
  logic       cfg_we;
  logic [3:0] cfg_idx;
  logic [2:0] cfg_field;
  logic [7:0] cfg_data;

  logic [7:0] p1_id, p2_id, p1_hp, p1_speed, p1_sk1, p1_sk2, p1_sk3;
  logic [7:0] p2_hp, p2_speed, p2_sk1, p2_sk2, p2_sk3;
  logic       p1_locked, p2_locked, sel_done;

  logic [7:0] w_p1_id, w_p2_id, w_p1_hp, w_p1_speed, w_p1_sk1, w_p1_sk2, w_p1_sk3;
  logic [7:0] w_p2_hp, w_p2_speed, w_p2_sk1, w_p2_sk2, w_p2_sk3;
  logic       w_p1_locked, w_p2_locked, w_sel_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pokemon_select_ctrl #(.COLS(4), .ROWS(2), .WRAP(0), .UNIQUE(1), .W(8)) dut (
    .clk(clk), .reset(reset), .scene_state(scene_state),
    .p1_keys(p1_keys), .p2_keys(p2_keys),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .p1_id(p1_id), .p2_id(p2_id),
    .p1_hp(p1_hp), .p1_speed(p1_speed), .p1_sk1(p1_sk1), .p1_sk2(p1_sk2), .p1_sk3(p1_sk3),
    .p2_hp(p2_hp), .p2_speed(p2_speed), .p2_sk1(p2_sk1), .p2_sk2(p2_sk2), .p2_sk3(p2_sk3),
    .p1_locked(p1_locked), .p2_locked(p2_locked), .sel_done(sel_done)
  );

  pokemon_select_ctrl #(.COLS(4), .ROWS(2), .WRAP(1), .UNIQUE(1), .W(8)) dut_w (
    .clk(clk), .reset(reset), .scene_state(scene_state),
    .p1_keys(p1_keys), .p2_keys(p2_keys),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .p1_id(w_p1_id), .p2_id(w_p2_id),
    .p1_hp(w_p1_hp), .p1_speed(w_p1_speed), .p1_sk1(w_p1_sk1), .p1_sk2(w_p1_sk2),
    .p1_sk3(w_p1_sk3),
    .p2_hp(w_p2_hp), .p2_speed(w_p2_speed), .p2_sk1(w_p2_sk1), .p2_sk2(w_p2_sk2),
    .p2_sk3(w_p2_sk3),
    .p1_locked(w_p1_locked), .p2_locked(w_p2_locked), .sel_done(w_sel_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; scene_state = 4'd2; p1_keys = 5'd0; p2_keys = 5'd0;
    cfg_we = 1'b0; cfg_idx = 4'd0; cfg_field = 3'd0; cfg_data = 8'd0;
    #12;
    chk("rst_p1_id", p1_id, 1);
    chk("rst_p2_id", p2_id, 8);
    chk("rst_locks", {p1_locked, p2_locked, sel_done}, 0);
    chk("rst_p1_hp", p1_hp, 50);
    chk("rst_p1_speed", p1_speed, 250);
    chk("rst_p1_sk", {p1_sk1, p1_sk2, p1_sk3}, {8'd30, 8'd40, 8'd50});
    chk("rst_p2_hp", p2_hp, 190);
    chk("rst_p2_speed", p2_speed, 145);
    reset = 1'b1;
    tick();                               // IDLE -> BROWSE

    // p2 from id 8: clamp vs wrap
    p2_keys = K_R; tick();
    chk("clamp_p2_R", p2_id, 8);
    chk("wrap_p2_R", w_p2_id, 5);
    p2_keys = 5'd0; tick();
    p2_keys = K_U; tick();
    chk("clamp_p2_U", p2_id, 4);
    chk("wrap_p2_U", w_p2_id, 1);
    p2_keys = 5'd0; tick();
    p2_keys = K_U; tick();
    chk("clamp_p2_U2", p2_id, 4);
    chk("wrap_p2_U2", w_p2_id, 5);
    p2_keys = 5'd0;

    // start scene returns cursors home
    scene_state = 4'd1; tick();
    chk("start_ids", {p1_id, p2_id}, {8'd1, 8'd8});
    scene_state = 4'd2; tick();

    // config write under p1's cursor (entry 0)
    cfg_we = 1'b1; cfg_idx = 4'd0; cfg_field = 3'd0; cfg_data = 8'd99; tick();
    cfg_we = 1'b0;
    chk("cfg_hp_edge1", p1_hp, 50);
    tick();
    chk("cfg_hp_edge2", p1_hp, 99);
    cfg_we = 1'b1; cfg_field = 3'd2; cfg_data = 8'd77; tick();
    cfg_field = 3'd5; cfg_data = 8'd7; tick();
    cfg_we = 1'b0; tick();
    chk("cfg_sk1", p1_sk1, 77);
    chk("cfg_bad_field", {p1_hp, p1_speed, p1_sk2, p1_sk3}, {8'd99, 8'd250, 8'd40, 8'd50});

    // p1 R,R,R,R,D
    p1_keys = K_R; tick(); chk("p1_R1", p1_id, 2); p1_keys = 5'd0; tick();
    chk("p1_id2_hp", p1_hp, 70);
    p1_keys = K_R; tick(); chk("p1_R2", p1_id, 3); p1_keys = 5'd0; tick();
    p1_keys = K_R; tick(); chk("p1_R3", p1_id, 4); p1_keys = 5'd0; tick();
    p1_keys = K_R; tick(); chk("p1_R4", p1_id, 4); p1_keys = 5'd0; tick();
    p1_keys = K_D; tick(); chk("p1_D", p1_id, 8); p1_keys = 5'd0; tick();
    tick();
    chk("p1_id8_stats", {p1_hp, p1_speed}, {8'd190, 8'd145});

    // held key moves once; two presses in one cycle are ignored
    p1_keys = K_L;
    for (int i = 0; i < 10; i++) tick();
    chk("p1_hold_L", p1_id, 7);
    p1_keys = 5'd0; tick();
    p1_keys = K_R | K_D; tick();
    chk("p1_multi", p1_id, 7);
    p1_keys = 5'd0; tick();
    p1_keys = K_U; tick(); chk("p1_U", p1_id, 3); p1_keys = 5'd0; tick();
    p1_keys = K_C; tick(); chk("p1_lock", p1_locked, 1); p1_keys = 5'd0; tick();

    // p2 to id 3: rejected; then id 4: accepted
    p2_keys = K_L; tick(); p2_keys = 5'd0; tick();
    p2_keys = K_U; tick(); chk("p2_to3", p2_id, 3); p2_keys = 5'd0; tick();
    p2_keys = K_C; tick(); chk("p2_dup_rej", p2_locked, 0); p2_keys = 5'd0; tick();
    p2_keys = K_R; tick(); chk("p2_to4", p2_id, 4); p2_keys = 5'd0; tick();
    p2_keys = K_C; tick();
    chk("p2_lock", p2_locked, 1);
    chk("sel_done_early", sel_done, 0);
    p2_keys = 5'd0; tick();
    chk("sel_done", sel_done, 1);
    p1_keys = K_L; tick(); chk("p1_locked_nomove", p1_id, 3); p1_keys = 5'd0; tick();

    // fight scene freezes everything
    scene_state = 4'd3;
    p1_keys = K_C; p2_keys = K_L;
    cfg_we = 1'b1; cfg_idx = 4'd2; cfg_field = 3'd0; cfg_data = 8'd5; tick();
    p1_keys = 5'd0; p2_keys = 5'd0; cfg_we = 1'b0; tick(); tick();
    chk("fight_locks", {p1_locked, p2_locked}, 2'b11);
    chk("fight_ids", {p1_id, p2_id}, {8'd3, 8'd4});
    chk("fight_stats", {p1_hp, p2_hp, p2_speed}, {8'd90, 8'd110, 8'd205});

    // start scene clears locks and done
    scene_state = 4'd1; tick();
    chk("start_locks", {p1_locked, p2_locked, sel_done}, 0);
    chk("start_ids2", {p1_id, p2_id}, {8'd1, 8'd8});
    tick();
    chk("start_stats", {p1_hp, p2_hp}, {8'd99, 8'd190});

    // asynchronous reset mid-choose
    scene_state = 4'd2; tick();
    p1_keys = K_R; tick(); p1_keys = 5'd0; tick();
    p1_keys = K_C; tick(); chk("pre_rst_lock", {p1_locked, p1_id}, {1'b1, 8'd2});
    p1_keys = 5'd0;
    #2 reset = 1'b0;
    #1;
    chk("arst_p1", {p1_locked, p1_id}, {1'b0, 8'd1});
    chk("arst_stats", {p1_hp, p1_sk1, p2_id}, {8'd50, 8'd30, 8'd8});
    chk("arst_done", sel_done, 0);
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pokemon_select_ctrl.md
# pokemon_select_ctrl

Two-player character-select controller for the choose scene. It replaces the single-cursor selector with the following:
- a parametrised COLS×ROWS grid;
- an independent cursor and lock FSM per player;
- optional edge wrap-around and duplicate-pick rejection;
- a runtime-writable stat table.

It sits between the debounced keypad/scene FSM and the fight-data path. It publishes each player's chosen id and stats and raises `sel_done` when both players have locked a pick.

## Interface
Parameters:
- `COLS`, 4, grid columns (1..8)
- `ROWS`, 2, grid rows (1..8); N = COLS*ROWS ≤ 16
- `WRAP`, 0, 1 = cursor wraps at grid edges, 0 = cursor clamps
- `UNIQUE`, 1, 1 = a player may not lock the id already locked by the other player
- `W`, 8, stat and id width

Ports:
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-low reset
- `scene_state` in 4: 1 = start, 2 = choose, 3 = fight, 4 = win; other codes are treated as fight
- `p1_keys` in 5: player 1 keys {U,D,L,R,C}, level inputs, already debounced
- `p2_keys` in 5: player 2 keys {U,D,L,R,C}, same format
- `cfg_we` in 1: stat-table write strobe
- `cfg_idx` in 4: table entry index (0-based)
- `cfg_field` in 3: 0 = hp, 1 = speed, 2 = skill1, 3 = skill2, 4 = skill3; codes 5..7 are ignored
- `cfg_data` in W: write data
- `p1_id`, `p2_id` out W: current 1-based cursor or locked id
- `p1_hp`, `p1_speed`, `p1_sk1`, `p1_sk2`, `p1_sk3` out W: stats for `p1_id`
- `p2_hp`, `p2_speed`, `p2_sk1`, `p2_sk2`, `p2_sk3` out W: stats for `p2_id`
- `p1_locked`, `p2_locked` out 1: player has confirmed a pick
- `sel_done` out 1: both players locked while scene = choose

## Operation
Stat table:
- N entries × 5 fields, registered.
- Reset contents for entry i: hp = 50+20i, speed = 250−15i, skill1 = 30, skill2 = 40, skill3 = 50 (all truncated to W).
- `cfg_we` writes the addressed entry and field at the clock edge. Writes with `cfg_idx` ≥ N or `cfg_field` ≥ 5 are ignored.

Key decoding:
- Each key is edge-detected per player through a registered previous sample. A press is the key high now and low in the previous cycle.
- A cycle with more than one new press for the same player is ignored for that player.

Cursor movement (grid position p = id−1; row = p/COLS, col = p%COLS):
- L/R move col by ∓1; U/D move row by ∓1.
- At an edge the cursor stays put when WRAP = 0. When WRAP = 1 it wraps to the opposite column or row, within the same row or column.

Per-player FSM:
- States: IDLE, BROWSE, LOCKED. Reset state is IDLE.
- Any state → IDLE whenever scene = start. In IDLE, p1 cursor = 1 and p2 cursor = N.
- IDLE → BROWSE when scene = choose.
- BROWSE: direction presses move the cursor. A C press → LOCKED, unless UNIQUE = 1 and the other player is LOCKED on the same id; then the press is rejected and the state stays BROWSE.
- Simultaneous C presses by both players on the same id with UNIQUE = 1: p1 locks, p2 is rejected.
- LOCKED: direction keys are ignored. A C press → BROWSE (unlock).
- In fight/win/other scenes all state, ids and stats hold. Scene = choose resumes from the held state.

Outputs:
- `sel_done` = p1 LOCKED & p2 LOCKED & scene = choose, registered.
- Stat outputs are registered lookups of the table at the current id. They refresh every cycle except in fight/win/other scenes, where they hold.

## Timing
- Reset (async assert, sync release) values:
  - p1_id = 1, p2_id = N
  - locks = 0, sel_done = 0
  - stat outputs = the table reset values for entries 0 and N−1 respectively
  - edge-detect registers = 0
- A key first sampled high at edge k: the cursor/FSM update is visible after edge k. The stats for the new id are visible after edge k+1.
- A key held high produces exactly one press. It must be released for at least one cycle before it counts again.
- A lock at edge k: `pN_locked` goes high after edge k; `sel_done` goes high after edge k+1 if the other player is already locked.
- A table write at edge k to the entry under a cursor shows on that player's stat output after edge k+1.
- Reset asserted mid-choose: all outputs go to their reset values immediately, without waiting for a clock.

## Test plan
- COLS = 4, ROWS = 2, WRAP = 0, scene = choose. p1 presses R,R,R,R,D → p1_id = 2,3,4,4,8. Two cycles after the last press, p1_hp = 190 and p1_speed = 145.
- WRAP = 1, p2 at id 8. p2 presses R → 5; then U → 1; then U → 5.
- UNIQUE = 1. p1 locks id 3; p2 moves to 3 and presses C → p2_locked stays 0. p2 moves to 4 and presses C → both locked, and `sel_done` = 1 one cycle after p2_locked.
- Hold p1 R high for 10 cycles → exactly one move. Press R and D in the same cycle → no move.
- cfg write hp = 99 to idx 0 while p1_id = 1 → p1_hp = 99 two edges after the write.
- With both players locked, switch scene to fight → outputs hold. Switch to start → IDLE, ids 1/N, locks and `sel_done` 0. Pulse reset low mid-choose → asynchronous clear to the reset values.
